// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: shares one 8-bit FIFO write port between two requesters.
// Grants are message-atomic: the owner keeps the port until it transfers a
// byte flagged last, or until it leaves req_valid low for TIMEOUT consecutive
// owned cycles (watchdog revoke, flagged by a one-cycle timeout_err pulse).
// Ties in IDLE are broken round-robin; the finishing owner loses priority.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   reqN_valid/data/last/ready   requester N byte handshake (N = 0, 1)
//   fifo_full          FIFO full flag; no push is issued while it is high
//   fifo_push/wdata    FIFO write strobe and byte
//   grant              one-hot current owner, 00 when idle
//   timeout_err        registered pulse in the cycle a grant is revoked
module fifo_push_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       fifo_full,
  output logic       fifo_push,
  output logic [7:0] fifo_wdata,
  output logic [1:0] grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             prio, prio_nxt;
  logic [CNT_W-1:0] wdog, wdog_nxt;
  logic             terr_nxt;

  // Signals of whichever requester currently owns the port.
  logic own_idx, own_valid, own_last, own_xfer;

  always_comb begin
    own_idx   = (state == OWN1);
    own_valid = own_idx ? req1_valid : req0_valid;
    own_last  = own_idx ? req1_last  : req0_last;
    own_xfer  = own_valid & ~fifo_full;
  end

  always_comb begin
    state_nxt  = state;
    prio_nxt   = prio;
    wdog_nxt   = wdog;
    terr_nxt   = 1'b0;
    grant      = 2'b00;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    fifo_push  = 1'b0;
    fifo_wdata = 8'h00;

    case (state)
      IDLE: begin
        // No byte is accepted here; the winner starts next cycle with a clean watchdog.
        wdog_nxt = '0;
        if (req0_valid && (!req1_valid || !prio)) state_nxt = OWN0;
        else if (req1_valid)                      state_nxt = OWN1;
      end
      OWN0: begin
        grant      = 2'b01;
        req0_ready = req0_valid & ~fifo_full;
        fifo_push  = req0_ready;
        fifo_wdata = req0_data;
      end
      OWN1: begin
        grant      = 2'b10;
        req1_ready = req1_valid & ~fifo_full;
        fifo_push  = req1_ready;
        fifo_wdata = req1_data;
      end
      default: state_nxt = IDLE;
    endcase

    if (state == OWN0 || state == OWN1) begin
      if (own_valid) begin
        // Valid high (even stalled by full) keeps the watchdog cleared.
        wdog_nxt = '0;
        if (own_xfer && own_last) begin
          state_nxt = IDLE;
          prio_nxt  = ~own_idx;
        end
      end else if (wdog == TO_M1) begin
        // TIMEOUT-th consecutive idle cycle: revoke; counter parks at TIMEOUT.
        wdog_nxt  = TO_MAX;
        state_nxt = IDLE;
        prio_nxt  = ~own_idx;
        terr_nxt  = 1'b1;
      end else begin
        wdog_nxt = wdog + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      prio        <= prio_nxt;
      wdog        <= wdog_nxt;
      timeout_err <= terr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter (TIMEOUT = 4): directed vector table, an
// asynchronous mid-message reset sequence, and a long randomized run checked
// cycle by cycle against a rule-level model of ownership and round-robin.
module tb_fifo_push_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       fifo_full, fifo_push, timeout_err;
  logic [7:0] fifo_wdata;
  logic [1:0] grant;

  fifo_push_arbiter #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_wdata(fifo_wdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rn, v0, l0, v1, l1, f;
    logic [7:0] d0, d1;
    logic [13:0] exp;  // {grant, push, wdata, ready0, ready1, timeout_err}
  } vec_t;

  vec_t vec[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [13:0] outs();
    return {grant, fifo_push, fifo_wdata, req0_ready, req1_ready, timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic rn, input logic v0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [7:0] d1, input logic l1, input logic f,
                     input logic [1:0] g, input logic p, input logic [7:0] wd,
                     input logic r0, input logic r1, input logic te);
    vec_t t;
    t.rn = rn; t.v0 = v0; t.d0 = d0; t.l0 = l0; t.v1 = v1; t.d1 = d1; t.l1 = l1; t.f = f;
    t.exp = {g, p, wd, r0, r1, te};
    vec.push_back(t);
  endtask

  task automatic drive(input logic rn, input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1, input logic f);
    rst = rn; req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1; fifo_full = f;
  endtask

  // Rule-level model state for the random run.
  int m_own, m_prio, m_cnt;
  bit m_terr;

  initial begin
    drive(0, 1, 8'h99, 1, 1, 8'h98, 1, 0);
    #1;
    chk("reset_comb", outs(), 14'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", outs(), 14'h0);

    // Single requester: 0x41 0x42 0x43(last)
    add(1, 1, 8'h41, 0, 0, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    add(1, 1, 8'h41, 0, 0, 8'h00, 0, 0, 2'b01, 1, 8'h41, 1, 0, 0);
    add(1, 1, 8'h42, 0, 0, 8'h00, 0, 0, 2'b01, 1, 8'h42, 1, 0, 0);
    add(1, 1, 8'h43, 1, 0, 8'h00, 0, 0, 2'b01, 1, 8'h43, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    // Contention from reset; 0 wins first, then 1 wins the rematch
    add(0, 1, 8'h10, 0, 1, 8'h20, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    add(1, 1, 8'h10, 0, 1, 8'h20, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    add(1, 1, 8'h10, 0, 1, 8'h20, 0, 0, 2'b01, 1, 8'h10, 1, 0, 0);
    add(1, 1, 8'h11, 1, 1, 8'h20, 0, 0, 2'b01, 1, 8'h11, 1, 0, 0);
    add(1, 1, 8'h10, 0, 1, 8'h20, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    add(1, 1, 8'h10, 0, 1, 8'h20, 0, 0, 2'b10, 1, 8'h20, 0, 1, 0);
    add(1, 1, 8'h10, 0, 1, 8'h21, 1, 0, 2'b10, 1, 8'h21, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    // Full backpressure for 5 cycles mid-message
    add(0, 1, 8'h61, 0, 0, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    add(1, 1, 8'h61, 0, 0, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    add(1, 1, 8'h61, 0, 0, 8'h00, 0, 0, 2'b01, 1, 8'h61, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(1, 1, 8'h62, 0, 0, 8'h00, 0, 1, 2'b01, 0, 8'h62, 0, 0, 0);
    add(1, 1, 8'h62, 1, 0, 8'h00, 0, 0, 2'b01, 1, 8'h62, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    // Watchdog: req1 sends 0x55 without last, then idles 4 cycles
    add(0, 0, 8'h00, 0, 1, 8'h55, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    add(1, 0, 8'h00, 0, 1, 8'h55, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);
    add(1, 0, 8'h00, 0, 1, 8'h55, 0, 0, 2'b10, 1, 8'h55, 0, 1, 0);
    for (int i = 0; i < TO; i++)
      add(1, 0, 8'h00, 0, 0, 8'h56, 0, 0, 2'b10, 0, 8'h56, 0, 0, 0);
    add(1, 1, 8'h70, 1, 1, 8'h56, 0, 0, 2'b00, 0, 8'h00, 0, 0, 1);
    add(1, 1, 8'h70, 1, 1, 8'h56, 0, 0, 2'b01, 1, 8'h70, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].rn, vec[i].v0, vec[i].d0, vec[i].l0, vec[i].v1, vec[i].d1, vec[i].l1, vec[i].f);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), vec[i].exp);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges while OWN0
    drive(1, 1, 8'h33, 0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    chk("arst_own", outs(), {2'b01, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0});
    #2 rst = 1'b0;
    #1;
    chk("arst_drop", outs(), 14'h0);
    @(posedge clk);
    #1;
    chk("arst_hold", outs(), 14'h0);
    drive(1, 0, 8'h00, 0, 1, 8'h44, 0, 0);
    @(negedge clk);
    chk("arst_idle", outs(), 14'h0);
    @(posedge clk);
    #1;
    chk("arst_g1", outs(), {2'b10, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0});

    // Randomized run against the model
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_own = -1; m_prio = 0; m_cnt = 0; m_terr = 0;
    begin
      int s0, s1;
      logic v0, v1, l0, l1, f, vx, lx, rx, er0, er1;
      logic [7:0] d0, d1, ewd;
      logic [1:0] eg;
      s0 = 0; s1 = 0;
      for (int c = 0; c < 10000; c++) begin
        v0 = ($urandom_range(0, 99) < 70);
        v1 = ($urandom_range(0, 99) < 70);
        l0 = ($urandom_range(0, 3) == 0);
        l1 = ($urandom_range(0, 3) == 0);
        f  = ($urandom_range(0, 4) == 0);
        d0 = 8'(s0 & 127);
        d1 = 8'(128 | (s1 & 127));
        drive(1, v0, d0, l0, v1, d1, l1, f);
        @(negedge clk);
        eg  = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
        er0 = (m_own == 0) && v0 && !f;
        er1 = (m_own == 1) && v1 && !f;
        ewd = (m_own == 0) ? d0 : (m_own == 1) ? d1 : 8'h00;
        chk($sformatf("rand%0d", c), outs(), {eg, er0 | er1, ewd, er0, er1, m_terr});
        if (fifo_push) chk($sformatf("nofull%0d", c), {13'b0, fifo_full}, 14'h0);
        if (er0) s0++;
        if (er1) s1++;
        m_terr = 0;
        if (m_own < 0) begin
          if (v0 && v1) m_own = m_prio;
          else if (v0) m_own = 0;
          else if (v1) m_own = 1;
          m_cnt = 0;
        end else begin
          vx = (m_own == 0) ? v0 : v1;
          lx = (m_own == 0) ? l0 : l1;
          rx = er0 | er1;
          if (vx) begin
            m_cnt = 0;
            if (rx && lx) begin
              m_prio = 1 - m_own;
              m_own = -1;
            end
          end else begin
            m_cnt++;
            if (m_cnt == TO) begin
              m_prio = 1 - m_own;
              m_own = -1;
              m_terr = 1;
            end
          end
        end
        @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
